// File: rtl/acc_cpu_mc.sv
// ---------------------------------------------------------------------------
// acc_cpu_mc : multicycle single-accumulator CPU.
//
// Fetches {opcode, operand} words from a combinational instruction ROM and
// executes them against a data RAM that may stretch accesses with mem_ready.
// Each instruction runs FETCH -> DECODE -> (MEM_RD | MEM_WR | HALT | FETCH).
//
// Ports:
//   clk              rising-edge system clock
//   rst              asynchronous reset, active low
//   im_addr_bus      instruction address (always the PC)
//   im_data_bus      instruction word {opcode[2:0], operand[ADDR_W-1:0]}
//   mem_in_addr_bus  data address, driven only during memory states
//   mem_in_data_bus  write data, always the accumulator
//   mem_out_data_bus read data from the data RAM
//   mem_rd / mem_wr  read / write request, held until mem_ready
//   mem_ready        data RAM accepts the request this cycle
//   go               leave HALT
//   halted           core is parked in HALT
//   acc_z            accumulator is zero
// ---------------------------------------------------------------------------
module acc_cpu_mc #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] im_addr_bus,
    input  logic [ADDR_W+2:0] im_data_bus,
    output logic [ADDR_W-1:0] mem_in_addr_bus,
    output logic [DATA_W-1:0] mem_in_data_bus,
    input  logic [DATA_W-1:0] mem_out_data_bus,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_ready,
    input  logic              go,
    output logic              halted,
    output logic              acc_z
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_RD,
        S_MEM_WR,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [ADDR_W+2:0] ir, ir_nxt;
    logic [DATA_W-1:0] acc, acc_nxt;
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] operand;

    assign opcode          = ir[ADDR_W+2:ADDR_W];
    assign operand         = ir[ADDR_W-1:0];
    assign im_addr_bus     = pc;
    assign mem_in_data_bus = acc;
    assign acc_z           = (acc == '0);

    // Accumulator result for the read-type opcodes; ADD wraps, carry dropped.
    function automatic logic [DATA_W-1:0] alu(input logic [2:0]        op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            OP_LDA:  r = b;
            default: r = a;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
            pc    <= '0;
            ir    <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
            acc   <= acc_nxt;
        end
    end

    // Bus outputs decode from the registered state alone, so an asynchronous
    // reset (which forces FETCH) drops mem_rd/mem_wr without waiting for a clock.
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        ir_nxt          = ir;
        acc_nxt         = acc;
        mem_rd          = 1'b0;
        mem_wr          = 1'b0;
        mem_in_addr_bus = '0;
        halted          = 1'b0;
        case (state)
            S_FETCH: begin
                ir_nxt    = im_data_bus;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_HLT: begin
                        pc_nxt    = pc + ADDR_W'(1);
                        state_nxt = S_HALT;
                    end
                    OP_SKZ: begin
                        pc_nxt    = pc + (acc_z ? ADDR_W'(2) : ADDR_W'(1));
                        state_nxt = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_nxt    = operand;
                        state_nxt = S_FETCH;
                    end
                    OP_STO:  state_nxt = S_MEM_WR;
                    default: state_nxt = S_MEM_RD;
                endcase
            end
            S_MEM_RD: begin
                mem_rd          = 1'b1;
                mem_in_addr_bus = operand;
                if (mem_ready) begin
                    acc_nxt   = alu(opcode, acc, mem_out_data_bus);
                    pc_nxt    = pc + ADDR_W'(1);
                    state_nxt = S_FETCH;
                end
            end
            S_MEM_WR: begin
                mem_wr          = 1'b1;
                mem_in_addr_bus = operand;
                if (mem_ready) begin
                    pc_nxt    = pc + ADDR_W'(1);
                    state_nxt = S_FETCH;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (go) state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_acc_cpu_mc.sv
// ---------------------------------------------------------------------------
// tb_acc_cpu_mc : self-checking bench for acc_cpu_mc.
// A default 8/5 core runs directed programs and a random program against an
// instruction-level model; a 16/8 core checks wide arithmetic and PC wrap.
// ---------------------------------------------------------------------------
module tb_acc_cpu_mc;

    localparam int DW  = 8;
    localparam int AW  = 5;
    localparam int IW  = AW + 3;
    localparam int WDW = 16;
    localparam int WAW = 8;
    localparam int WIW = WAW + 3;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] im_addr, mem_addr;
    logic [IW-1:0] im_data;
    logic [DW-1:0] wdata, rdata;
    logic          mem_rd, mem_wr, mem_ready, go, halted, acc_z;
    logic [IW-1:0] imem [2**AW];
    logic [DW-1:0] dmem [2**AW];

    assign im_data = imem[im_addr];
    assign rdata   = dmem[mem_addr];

    logic [WAW-1:0] w_im_addr, w_mem_addr;
    logic [WIW-1:0] w_im_data;
    logic [WDW-1:0] w_wdata, w_rdata;
    logic           w_mem_rd, w_mem_wr, w_mem_ready, w_go, w_halted, w_acc_z;
    logic [WIW-1:0] w_imem [2**WAW];
    logic [WDW-1:0] w_dmem [2**WAW];

    assign w_im_data = w_imem[w_im_addr];
    assign w_rdata   = w_dmem[w_mem_addr];

    acc_cpu_mc #(.DATA_W(DW), .ADDR_W(AW)) u_dut (
        .clk(clk), .rst(rst),
        .im_addr_bus(im_addr), .im_data_bus(im_data),
        .mem_in_addr_bus(mem_addr), .mem_in_data_bus(wdata),
        .mem_out_data_bus(rdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_ready(mem_ready), .go(go), .halted(halted), .acc_z(acc_z)
    );

    acc_cpu_mc #(.DATA_W(WDW), .ADDR_W(WAW)) u_wide (
        .clk(clk), .rst(rst),
        .im_addr_bus(w_im_addr), .im_data_bus(w_im_data),
        .mem_in_addr_bus(w_mem_addr), .mem_in_data_bus(w_wdata),
        .mem_out_data_bus(w_rdata), .mem_rd(w_mem_rd), .mem_wr(w_mem_wr),
        .mem_ready(w_mem_ready), .go(w_go), .halted(w_halted), .acc_z(w_acc_z)
    );

    // Instruction-level reference state
    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_acc;
    logic [DW-1:0] ref_dmem [2**AW];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [IW-1:0] ins(input logic [2:0] op, input logic [AW-1:0] a);
        return {op, a};
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_mem;
        for (int i = 0; i < 2**AW; i++) begin
            imem[i] = '0;
            dmem[i] = '0;
        end
    endtask

    task automatic do_reset;
        rst       = 1'b0;
        mem_ready = 1'b0;
        go        = 1'b0;
        tick;
        tick;
        rst   = 1'b1;
        m_pc  = '0;
        m_acc = '0;
        for (int i = 0; i < 2**AW; i++) ref_dmem[i] = dmem[i];
    endtask

    // Drives one instruction from FETCH to the next FETCH, acting as the data
    // RAM (with 'waits' not-ready cycles) and advancing the reference model.
    // Returns the number of cycles whose bus activity departed from the ISA.
    task automatic exec_one(input int waits, output int bad);
        logic [2:0]    op;
        logic [AW-1:0] a, nxt_pc, wa;
        logic [DW-1:0] nxt_acc, wd;
        logic          is_rd, is_wr, do_wr;
        int            hold;
        bad     = 0;
        op      = imem[m_pc][IW-1:AW];
        a       = imem[m_pc][AW-1:0];
        is_wr   = (op == OP_STO);
        is_rd   = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
        nxt_acc = m_acc;
        nxt_pc  = AW'(int'(m_pc) + 1);
        case (op)
            OP_SKZ:  nxt_pc = (m_acc == '0) ? AW'(int'(m_pc) + 2) : AW'(int'(m_pc) + 1);
            OP_JMP:  nxt_pc = a;
            OP_ADD:  nxt_acc = DW'(int'(m_acc) + int'(ref_dmem[a]));
            OP_AND:  nxt_acc = m_acc & ref_dmem[a];
            OP_XOR:  nxt_acc = m_acc ^ ref_dmem[a];
            OP_LDA:  nxt_acc = ref_dmem[a];
            OP_STO:  ref_dmem[a] = m_acc;
            default: ;
        endcase
        if (im_addr !== m_pc || mem_rd !== 1'b0 || mem_wr !== 1'b0 || halted !== 1'b0) bad++;
        mem_ready = 1'($urandom_range(0, 1));
        go        = 1'($urandom_range(0, 1));
        tick;
        if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || halted !== 1'b0 || mem_addr !== '0) bad++;
        mem_ready = 1'($urandom_range(0, 1));
        go        = 1'($urandom_range(0, 1));
        tick;
        if (is_rd || is_wr) begin
            for (int k = 0; k <= waits; k++) begin
                if (mem_rd !== is_rd || mem_wr !== is_wr || mem_addr !== a || halted !== 1'b0) bad++;
                mem_ready = (k == waits);
                go        = 1'($urandom_range(0, 1));
                do_wr     = mem_wr && (k == waits);
                wa        = mem_addr;
                wd        = wdata;
                tick;
                if (do_wr) dmem[wa] = wd;
            end
        end
        mem_ready = 1'b0;
        go        = 1'b0;
        if (op == OP_HLT) begin
            hold = $urandom_range(0, 3);
            for (int k = 0; k < hold; k++) begin
                if (halted !== 1'b1 || mem_rd !== 1'b0 || mem_wr !== 1'b0 || im_addr !== nxt_pc) bad++;
                mem_ready = 1'($urandom_range(0, 1));
                tick;
            end
            if (halted !== 1'b1) bad++;
            mem_ready = 1'b0;
            go = 1'b1;
            tick;
            go = 1'b0;
        end
        m_pc  = nxt_pc;
        m_acc = nxt_acc;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick;
        n_checks++; if (im_addr !== '0) $display("FAIL reset_pc: got %0d want 0", im_addr); else n_pass++;
        n_checks++; if (mem_rd !== 1'b0) $display("FAIL reset_rd: got %b want 0", mem_rd); else n_pass++;
        n_checks++; if (mem_wr !== 1'b0) $display("FAIL reset_wr: got %b want 0", mem_wr); else n_pass++;
        n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else n_pass++;
        n_checks++; if (mem_addr !== '0) $display("FAIL reset_addr: got %0d want 0", mem_addr); else n_pass++;
        n_checks++; if (acc_z !== 1'b1) $display("FAIL reset_accz: got %b want 1", acc_z); else n_pass++;
        n_checks++; if (wdata !== '0) $display("FAIL reset_data: got %h want 0", wdata); else n_pass++;
        n_checks++; if (w_im_addr !== '0) $display("FAIL reset_wide_pc: got %0d want 0", w_im_addr); else n_pass++;
    endtask

    task automatic test_lda;
        int rd_cycles, addr_bad;
        clear_mem;
        imem[0] = ins(OP_LDA, 5'd3);
        dmem[3] = 8'h5A;
        do_reset;
        rd_cycles = 0;
        addr_bad  = 0;
        for (int c = 0; c < 3; c++) begin
            mem_ready = 1'b1;
            if (mem_rd === 1'b1) begin
                rd_cycles++;
                if (mem_addr !== 5'd3) addr_bad++;
            end
            tick;
        end
        mem_ready = 1'b0;
        n_checks++; if (rd_cycles != 1) $display("FAIL lda_rd_cycles: got %0d want 1", rd_cycles); else n_pass++;
        n_checks++; if (addr_bad != 0) $display("FAIL lda_addr: %0d cycles with wrong address, want 0", addr_bad); else n_pass++;
        n_checks++; if (im_addr !== 5'd1) $display("FAIL lda_pc: got %0d want 1", im_addr); else n_pass++;
        n_checks++; if (wdata !== 8'h5A) $display("FAIL lda_acc: got %h want 5a", wdata); else n_pass++;
    endtask

    task automatic test_add_wrap;
        int bad, tot;
        clear_mem;
        imem[0] = ins(OP_LDA, 5'd1);
        imem[1] = ins(OP_ADD, 5'd2);
        imem[2] = ins(OP_XOR, 5'd3);
        dmem[1] = 8'hF0;
        dmem[2] = 8'h20;
        dmem[3] = 8'h10;
        do_reset;
        exec_one(0, bad); tot = bad;
        exec_one($urandom_range(0, 2), bad); tot += bad;
        n_checks++; if (wdata !== 8'h10) $display("FAIL add_wrap_acc: got %h want 10", wdata); else n_pass++;
        n_checks++; if (acc_z !== 1'b0) $display("FAIL add_wrap_accz: got %b want 0", acc_z); else n_pass++;
        exec_one($urandom_range(0, 2), bad); tot += bad;
        n_checks++; if (wdata !== 8'h00) $display("FAIL xor_acc: got %h want 00", wdata); else n_pass++;
        n_checks++; if (acc_z !== 1'b1) $display("FAIL xor_accz: got %b want 1", acc_z); else n_pass++;
        n_checks++; if (tot != 0) $display("FAIL add_bus: %0d bad cycles, want 0", tot); else n_pass++;
    endtask

    task automatic test_skz;
        int bad, tot;
        logic [AW-1:0] target, want;
        for (int s = 0; s < 3; s++) begin
            clear_mem;
            target  = (s == 2) ? 5'd31 : 5'd4;
            want    = (s == 0) ? 5'd6 : (s == 1) ? 5'd5 : 5'd1;
            dmem[1] = (s == 1) ? 8'h01 : 8'h00;
            imem[0] = ins(OP_LDA, 5'd1);
            imem[1] = ins(OP_JMP, target);
            imem[target] = ins(OP_SKZ, 5'd0);
            do_reset;
            exec_one(0, bad); tot = bad;
            exec_one(0, bad); tot += bad;
            exec_one(0, bad); tot += bad;
            n_checks++; if (im_addr !== want) $display("FAIL skz_%0d_pc: got %0d want %0d", s, im_addr, want); else n_pass++;
            n_checks++; if (tot != 0) $display("FAIL skz_%0d_bus: %0d bad cycles, want 0", s, tot); else n_pass++;
        end
    endtask

    task automatic test_wait_sto;
        int bad, stable, early;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        clear_mem;
        imem[0] = ins(OP_LDA, 5'd1);
        imem[1] = ins(OP_STO, 5'd9);
        dmem[1] = 8'hC3;
        do_reset;
        exec_one(0, bad);
        tick;
        tick;
        stable = 0;
        early  = 0;
        wa     = '0;
        wd     = '0;
        for (int k = 0; k < 4; k++) begin
            if (mem_wr === 1'b1 && mem_rd === 1'b0 && mem_addr === 5'd9 && wdata === 8'hC3) stable++;
            if (im_addr !== 5'd1) early++;
            mem_ready = (k == 3);
            wa = mem_addr;
            wd = wdata;
            tick;
            if (k == 3 && mem_wr === 1'b0) dmem[wa] = wd;
        end
        mem_ready = 1'b0;
        if (mem_wr === 1'b0) ;
        else dmem[wa] = wd;
        n_checks++; if (stable != 4) $display("FAIL sto_stable: got %0d cycles want 4", stable); else n_pass++;
        n_checks++; if (early != 0) $display("FAIL sto_pc_early: %0d cycles moved, want 0", early); else n_pass++;
        n_checks++; if (mem_wr !== 1'b0) $display("FAIL sto_wr_release: got %b want 0", mem_wr); else n_pass++;
        n_checks++; if (im_addr !== 5'd2) $display("FAIL sto_pc: got %0d want 2", im_addr); else n_pass++;
        n_checks++; if (dmem[9] !== 8'hC3) $display("FAIL sto_data: got %h want c3", dmem[9]); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL sto_lda_bus: %0d bad cycles, want 0", bad); else n_pass++;
    endtask

    task automatic test_halt;
        int bad, idle_bad;
        clear_mem;
        imem[0] = ins(OP_JMP, 5'd7);
        imem[7] = ins(OP_HLT, 5'd0);
        imem[8] = ins(OP_LDA, 5'd2);
        dmem[2] = 8'h77;
        do_reset;
        exec_one(0, bad);
        tick;
        tick;
        n_checks++; if (halted !== 1'b1) $display("FAIL halt_enter: got %b want 1", halted); else n_pass++;
        idle_bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (halted !== 1'b1 || im_addr !== 5'd8 || mem_rd !== 1'b0 || mem_wr !== 1'b0) idle_bad++;
            mem_ready = 1'($urandom_range(0, 1));
            tick;
        end
        mem_ready = 1'b0;
        n_checks++; if (idle_bad != 0) $display("FAIL halt_idle: %0d bad cycles, want 0", idle_bad); else n_pass++;
        go = 1'b1;
        tick;
        go = 1'b0;
        n_checks++; if (halted !== 1'b0) $display("FAIL halt_resume: got %b want 0", halted); else n_pass++;
        n_checks++; if (im_addr !== 5'd8) $display("FAIL halt_resume_pc: got %0d want 8", im_addr); else n_pass++;
        m_pc = 5'd8;
        exec_one(1, bad);
        n_checks++; if (wdata !== 8'h77) $display("FAIL halt_after_lda: got %h want 77", wdata); else n_pass++;
    endtask

    task automatic test_async_reset;
        int bad;
        clear_mem;
        imem[0] = ins(OP_LDA, 5'd5);
        imem[1] = ins(OP_LDA, 5'd6);
        dmem[5] = 8'h3C;
        dmem[6] = 8'h99;
        do_reset;
        exec_one(0, bad);
        mem_ready = 1'b0;
        tick;
        tick;
        n_checks++; if (mem_rd !== 1'b1) $display("FAIL arst_pre_rd: got %b want 1", mem_rd); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (mem_rd !== 1'b0) $display("FAIL arst_rd_drop: got %b want 0", mem_rd); else n_pass++;
        n_checks++; if (im_addr !== '0) $display("FAIL arst_pc: got %0d want 0", im_addr); else n_pass++;
        n_checks++; if (wdata !== '0) $display("FAIL arst_acc: got %h want 0", wdata); else n_pass++;
        @(negedge clk);
        rst   = 1'b1;
        m_pc  = '0;
        m_acc = '0;
        exec_one(1, bad);
        n_checks++; if (im_addr !== 5'd1 || wdata !== 8'h3C)
            $display("FAIL arst_restart: got pc %0d acc %h want pc 1 acc 3c", im_addr, wdata); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL arst_bus: %0d bad cycles, want 0", bad); else n_pass++;
    endtask

    task automatic test_wide;
        for (int i = 0; i < 2**WAW; i++) begin
            w_imem[i] = '0;
            w_dmem[i] = '0;
        end
        w_imem[0]     = {OP_JMP, 8'hFE};
        w_imem[8'hFE] = {OP_LDA, 8'h80};
        w_imem[8'hFF] = {OP_ADD, 8'h81};
        w_dmem[8'h80] = 16'hFFFF;
        w_dmem[8'h81] = 16'h0002;
        w_mem_ready   = 1'b1;
        do_reset;
        for (int c = 0; c < 5; c++) tick;
        n_checks++; if (w_im_addr !== 8'hFF || w_wdata !== 16'hFFFF)
            $display("FAIL wide_lda: got pc %h acc %h want pc ff acc ffff", w_im_addr, w_wdata); else n_pass++;
        for (int c = 0; c < 3; c++) tick;
        n_checks++; if (w_wdata !== 16'h0001) $display("FAIL wide_add: got %h want 0001", w_wdata); else n_pass++;
        n_checks++; if (w_im_addr !== 8'h00) $display("FAIL wide_pc_wrap: got %h want 00", w_im_addr); else n_pass++;
        n_checks++; if (w_acc_z !== 1'b0) $display("FAIL wide_accz: got %b want 0", w_acc_z); else n_pass++;
    endtask

    task automatic test_random;
        int bad, mem_bad;
        for (int i = 0; i < 2**AW; i++) begin
            imem[i] = IW'($urandom);
            dmem[i] = DW'($urandom);
        end
        do_reset;
        for (int n = 0; n < 300; n++) begin
            exec_one($urandom_range(0, 2), bad);
            n_checks++; if (bad != 0) $display("FAIL rnd_bus_%0d: %0d bad cycles, want 0", n, bad); else n_pass++;
            n_checks++; if (im_addr !== m_pc) $display("FAIL rnd_pc_%0d: got %0d want %0d", n, im_addr, m_pc); else n_pass++;
            n_checks++; if (wdata !== m_acc) $display("FAIL rnd_acc_%0d: got %h want %h", n, wdata, m_acc); else n_pass++;
            n_checks++; if (acc_z !== (m_acc == '0)) $display("FAIL rnd_accz_%0d: got %b want %b", n, acc_z, (m_acc == '0)); else n_pass++;
        end
        mem_bad = 0;
        for (int i = 0; i < 2**AW; i++) if (dmem[i] !== ref_dmem[i]) mem_bad++;
        n_checks++; if (mem_bad != 0) $display("FAIL rnd_dmem: %0d words differ, want 0", mem_bad); else n_pass++;
    endtask

    initial begin
        rst         = 1'b0;
        mem_ready   = 1'b0;
        go          = 1'b0;
        w_mem_ready = 1'b1;
        w_go        = 1'b0;
        for (int i = 0; i < 2**WAW; i++) begin
            w_imem[i] = '0;
            w_dmem[i] = '0;
        end
        clear_mem;
        @(negedge clk);
        test_reset;
        test_lda;
        test_add_wrap;
        test_skz;
        test_wait_sto;
        test_halt;
        test_async_reset;
        test_wide;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
